multicycle_control: RTL and testbench

Multi-cycle sequencing controller for the MIPS datapath. It replaces the single-cycle `control` decoder with a registered state machine. Each instruction is split into fetch, decode, execute, memory and write-back steps, and the controller drives the shared ALU, register file, PC and unified memory on every step. Memory accesses stall on a ready handshake. The `alu_op` output feeds the existing `alu_control` unit unchanged.

---
 rtl/multicycle_control.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the MIPS datapath.
// Steps each instruction through fetch, decode, execute, memory and write-back.
// Control outputs are decoded from the current state, and three of them also
// depend on mem_ready. Memory steps wait on the mem_ready handshake.
// Reset is synchronous and active-high. While rst is high, every output is 0.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  instr_op,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] retired_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EX    = 4'd6,
    S_R_WB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t      state_r;
  state_t      next_state_s;
  logic [5:0]  op_r;
  logic [31:0] retired_count_r;

  // The zero flag steers only the datapath's branch gating and is not needed here.
  logic unused_s;
  assign unused_s = zero;

  // State register, opcode latched in DECODE, and the retirement counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_FETCH;
      op_r            <= 6'b000000;
      retired_count_r <= 32'd0;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_DECODE) begin
        op_r <= instr_op;
      end else begin
        op_r <= op_r;
      end
      if (instr_done) begin
        retired_count_r <= retired_count_r + 32'd1;
      end else begin
        retired_count_r <= retired_count_r;
      end
    end
  end

  // Next-state selection and output decode. While rst is high, every output stays 0.
  always_comb begin
    next_state_s  = state_r;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    state         = 4'd0;
    retired_count = 32'd0;
    if (rst) begin
      next_state_s = S_FETCH;
    end else begin
      state         = state_r;
      retired_count = retired_count_r;
      case (state_r)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) begin
            next_state_s = S_DECODE;
          end else begin
            next_state_s = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (instr_op)
            OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
            OP_RTYPE:     next_state_s = S_R_EX;
            OP_BEQ:       next_state_s = S_BRANCH;
            OP_J:         next_state_s = S_JUMP;
            OP_ADDI:      next_state_s = S_ADDI_EX;
            default: begin
              // An unsupported opcode retires here, in DECODE.
              illegal_op   = 1'b1;
              instr_done   = 1'b1;
              next_state_s = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (op_r == OP_LW) begin
            next_state_s = S_MEM_RD;
          end else begin
            next_state_s = S_MEM_WR;
          end
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) begin
            next_state_s = S_MEM_WB;
          end else begin
            next_state_s = S_MEM_RD;
          end
        end
        S_MEM_WB: begin
          reg_write    = 1'b1;
          mem_to_reg   = 1'b1;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) begin
            next_state_s = S_FETCH;
          end else begin
            next_state_s = S_MEM_WR;
          end
        end
        S_R_EX: begin
          alu_src_a    = 1'b1;
          alu_op       = 2'b10;
          next_state_s = S_R_WB;
        end
        S_R_WB: begin
          reg_write    = 1'b1;
          reg_dst      = 1'b1;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
          next_state_s  = S_FETCH;
        end
        S_JUMP: begin
          pc_write     = 1'b1;
          pc_source    = 2'b10;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end
        S_ADDI_EX: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          next_state_s = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          reg_write    = 1'b1;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end
        default: begin
          next_state_s = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// Each instruction is expanded into the cycle-by-cycle list of control words
// it must produce. A single compare process checks the DUT against that list
// on every cycle.
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [5:0]  instr_op;
  logic        mem_ready;
  logic        zero;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic        instr_done, illegal_op;
  logic [3:0]  state;
  logic [31:0] retired_count;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state), .retired_count(retired_count)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
  } ctl_t;

  typedef struct {
    ctl_t c;
    bit   is_rst;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_count = 32'd0;
  int          mw_cycles = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control words for each step of an instruction, taken from the operation table.
  function automatic ctl_t c_fetch(input logic rdy);
    ctl_t c = '0;
    c.st = 4'd0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
    c.ir_write = rdy; c.pc_write = rdy;
    return c;
  endfunction
  function automatic ctl_t c_decode(input logic ill);
    ctl_t c = '0;
    c.st = 4'd1; c.alu_src_b = 2'b11; c.illegal_op = ill; c.instr_done = ill;
    return c;
  endfunction
  function automatic ctl_t c_addr(input logic [3:0] st);
    ctl_t c = '0;
    c.st = st; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic ctl_t c_mem(input logic [3:0] st, input logic wr, input logic rdy);
    ctl_t c = '0;
    c.st = st; c.i_or_d = 1'b1; c.mem_read = !wr; c.mem_write = wr;
    c.instr_done = wr & rdy;
    return c;
  endfunction
  function automatic ctl_t c_wb(input logic [3:0] st, input logic from_mem, input logic rd);
    ctl_t c = '0;
    c.st = st; c.reg_write = 1'b1; c.mem_to_reg = from_mem; c.reg_dst = rd;
    c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_rex();
    ctl_t c = '0;
    c.st = 4'd6; c.alu_src_a = 1'b1; c.alu_op = 2'b10;
    return c;
  endfunction
  function automatic ctl_t c_branch();
    ctl_t c = '0;
    c.st = 4'd8; c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
    c.pc_source = 2'b01; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_jump();
    ctl_t c = '0;
    c.st = 4'd9; c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1;
    return c;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
           (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
  endfunction

  // Compare process: one expected entry per cycle, checked on the falling edge.
  always @(negedge clk) begin
    ctl_t obs;
    exp_t e;
    obs = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, illegal_op};
    if (mem_write) mw_cycles = mw_cycles + 1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total = total + 1;
      if (e.is_rst) begin
        if (obs != '0 || retired_count != 32'd0) begin
          bad = bad + 1;
          $display("FAIL reset_outputs t=%0t got ctl=%h cnt=%h exp ctl=0 cnt=0", $time, obs, retired_count);
        end
        model_count = 32'd0;
      end else begin
        if (obs != e.c) begin
          bad = bad + 1;
          $display("FAIL ctl_word t=%0t got=%h exp=%h (exp state %0d)", $time, obs, e.c, e.c.st);
        end
        total = total + 1;
        if (retired_count != model_count) begin
          bad = bad + 1;
          $display("FAIL retired_count t=%0t got=%h exp=%h", $time, retired_count, model_count);
        end
        if (e.c.instr_done) model_count = model_count + 32'd1;
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step(input logic [5:0] op, input logic rdy, input ctl_t c);
    exp_t e;
    instr_op  = op;
    mem_ready = rdy;
    zero      = rnd();
    e.c = c; e.is_rst = 1'b0;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic rst_step();
    exp_t e;
    rst       = 1'b1;
    mem_ready = rnd();
    instr_op  = 6'($urandom);
    e.c = '0; e.is_rst = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Expand one instruction into its cycles. fw and mw are the mem_ready=0 cycles in
  // fetch and in the memory step. After DECODE the opcode bus shows a different
  // opcode, so a controller that re-reads instr_op takes the wrong path.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    logic [5:0] junk;
    junk = op ^ 6'b001000;
    for (int i = 0; i < fw; i++) step(op, 1'b0, c_fetch(1'b0));
    step(op, 1'b1, c_fetch(1'b1));
    step(op, rnd(), c_decode(!legal(op)));
    case (op)
      6'b100011: begin
        step(junk, rnd(), c_addr(4'd2));
        for (int i = 0; i < mw; i++) step(junk, 1'b0, c_mem(4'd3, 1'b0, 1'b0));
        step(junk, 1'b1, c_mem(4'd3, 1'b0, 1'b1));
        step(junk, rnd(), c_wb(4'd4, 1'b1, 1'b0));
      end
      6'b101011: begin
        step(junk, rnd(), c_addr(4'd2));
        for (int i = 0; i < mw; i++) step(junk, 1'b0, c_mem(4'd5, 1'b1, 1'b0));
        step(junk, 1'b1, c_mem(4'd5, 1'b1, 1'b1));
      end
      6'b000000: begin
        step(junk, rnd(), c_rex());
        step(junk, rnd(), c_wb(4'd7, 1'b0, 1'b1));
      end
      6'b000100: step(junk, rnd(), c_branch());
      6'b000010: step(junk, rnd(), c_jump());
      6'b001000: begin
        step(junk, rnd(), c_addr(4'd10));
        step(junk, rnd(), c_wb(4'd11, 1'b0, 1'b0));
      end
      default: begin
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Directed sequence.
  initial begin
    rst = 1'b1; instr_op = 6'd0; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    rst_step();
    rst_step();

    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 0);
    check_lit("count_after_r_lw", retired_count, 32'd2);

    mw_cycles = 0;
    run_instr(6'b101011, 0, 3);
    check_lit("sw_mem_write_cycles", 32'(mw_cycles), 32'd4);

    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);
    check_lit("count_after_illegal", retired_count, 32'd6);
    run_instr(6'b001000, 2, 0);
    run_instr(6'b100011, 1, 2);
    run_instr(6'b000001, 0, 0);
    check_lit("count_before_reset", retired_count, 32'd9);

    // Reset while the R-type instruction is in R_EX.
    step(6'b000000, 1'b1, c_fetch(1'b1));
    step(6'b000000, rnd(), c_decode(1'b0));
    rst_step();
    check_lit("state_after_reset", 32'(state), 32'd0);
    check_lit("count_after_reset", retired_count, 32'd0);
    run_instr(6'b000000, 0, 0);

    // Reset during a load's memory wait.
    step(6'b100011, 1'b1, c_fetch(1'b1));
    step(6'b100011, rnd(), c_decode(1'b0));
    step(6'b101011, rnd(), c_addr(4'd2));
    step(6'b101011, 1'b0, c_mem(4'd3, 1'b0, 1'b0));
    step(6'b101011, 1'b0, c_mem(4'd3, 1'b0, 1'b0));
    rst_step();
    check_lit("count_after_wait_reset", retired_count, 32'd0);
    run_instr(6'b101011, 1, 1);

    // Counter wrap: hold the counter at all-ones for one idle fetch cycle.
    mem_ready = 1'b0;
    force dut.retired_count_r = 32'hFFFF_FFFF;
    model_count = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.retired_count_r;
    check_lit("count_preloaded", retired_count, 32'hFFFF_FFFF);
    run_instr(6'b000010, 0, 0);
    check_lit("count_wrapped", retired_count, 32'd0);
    run_instr(6'b000000, 0, 0);
    check_lit("count_after_wrap", retired_count, 32'd1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
